// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline register.
//   PIPE_WIDTH : default payload width
//   state_t    : handshake FSM encodings (2'b11 is illegal and recovers to EMPTY)
package pipe_skid_reg_pkg;
  localparam int PIPE_WIDTH = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;
endpackage

// File: rtl/pipe_skid_reg_flopenr.sv
// flopenr_param: WIDTH-bit register with load enable, async active-low reset to 0.
//   clk   : rising-edge clock
//   rst   : async reset, active-low
//   en    : load d on the next edge
//   d / q : data in / registered data out
module flopenr_param #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry elastic pipeline register with registered in_ready.
// The main register drives out_data; the skid register catches the one beat
// that arrives while downstream stalls, so in_ready never depends
// combinationally on out_ready.
//   clk, rst            : clock, async active-low reset
//   flush               : synchronous discard of all held entries
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_data             : upstream payload
//   out_valid/out_ready : downstream handshake (out_valid registered)
//   out_data            : head entry, registered
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  state_t           state;
  logic             accept, emit;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign accept = in_valid  & in_ready;
  assign emit   = out_valid & out_ready;

  // Data-path enables. Flush suppresses loads; stale data is harmless
  // because out_valid drops with it.
  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    if (!flush) begin
      case (state)
        EMPTY: main_en = accept;
        BUSY: begin
          main_en = accept & emit;
          skid_en = accept & ~emit;
        end
        FULL: begin
          main_en = emit;
          main_d  = skid_q;   // skid entry moves up to head
        end
        default: ;
      endcase
    end
  end

  flopenr_param #(.WIDTH(WIDTH)) u_main (
    .clk (clk), .rst (rst), .en (main_en), .d (main_d),  .q (out_data)
  );

  flopenr_param #(.WIDTH(WIDTH)) u_skid (
    .clk (clk), .rst (rst), .en (skid_en), .d (in_data), .q (skid_q)
  );

  // State and both handshake outputs are registered together so that
  // in_ready reflects the next state (!= FULL) without a comb path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state     <= BUSY;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
        end
        BUSY: begin
          if (accept && !emit) begin
            state     <= FULL;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else if (!accept && emit) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        FULL: if (emit) begin
          state     <= BUSY;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random
// traffic, compared against a 2-deep FIFO queue model.
module tb_pipe_skid_reg;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int vecs = 0;
  int errs = 0;
  logic [W-1:0] q[$];       // model contents, head = q[0]
  logic [W-1:0] emitted[$];

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    if (q.size() > 0) chk({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // Apply one cycle of inputs, advance the model over the edge, then check.
  task automatic step(input string tag, input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl);
    logic acc, em;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (q.size() < 2);
    em  = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (em)  void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    #1 check_model(tag);
  endtask

  initial begin
    int idx;
    logic iv, ordy;

    // reset values
    #12;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready",  32'(in_ready),  1);
    chk("rst.out_data",  32'(out_data),  0);
    rst = 1'b1;

    // streaming 1..4, no bubbles
    for (int i = 1; i <= 4; i++) begin
      step("stream", 1'b1, W'(i), 1'b1, 1'b0);
      chk("stream.data", 32'(out_data), i);
      chk("stream.ready", 32'(in_ready), 1);
    end
    step("stream.drain", 1'b0, '0, 1'b1, 1'b0);

    // skid: BUSY holding 1, stall, accept 2
    step("skid", 1'b1, 3'd1, 1'b0, 1'b0);
    step("skid", 1'b1, 3'd2, 1'b0, 1'b0);
    chk("skid.in_ready_full", 32'(in_ready), 0);
    chk("skid.hold1", 32'(out_data), 1);
    step("skid.emit1", 1'b0, '0, 1'b1, 1'b0);
    chk("skid.head2", 32'(out_data), 2);
    chk("skid.in_ready_back", 32'(in_ready), 1);
    step("skid.emit2", 1'b0, '0, 1'b1, 1'b0);

    // stall hold for 10 cycles with 6 at head
    step("stall", 1'b1, 3'd6, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("stall", 1'b1, W'($urandom), 1'b0, 1'b0);
      chk("stall.data", 32'(out_data), 6);
      chk("stall.valid", 32'(out_valid), 1);
    end
    step("stall.drain", 1'b0, '0, 1'b1, 1'b0);
    step("stall.drain", 1'b0, '0, 1'b1, 1'b0);

    // flush from FULL with a concurrent offer of 7
    step("flush", 1'b1, 3'd3, 1'b0, 1'b0);
    step("flush", 1'b1, 3'd4, 1'b0, 1'b0);
    step("flush", 1'b1, 3'd7, 1'b1, 1'b1);
    chk("flush.out_valid", 32'(out_valid), 0);
    chk("flush.in_ready", 32'(in_ready), 1);
    step("flush.idle", 1'b0, '0, 1'b1, 1'b0);
    step("flush.idle", 1'b0, '0, 1'b1, 1'b0);

    // bubbles: 1,2,3 on alternate cycles, random out_ready
    idx = 0;
    emitted.delete();
    for (int c = 0; c < 60; c++) begin
      iv   = (c % 2 == 0) && (idx < 3);
      ordy = 1'($urandom);
      if (out_valid && ordy) emitted.push_back(out_data);
      if (iv && q.size() < 2) idx++;
      step("bubble", iv, W'(iv ? idx : 0), ordy, 1'b0);
    end
    chk("bubble.count", 32'(emitted.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < emitted.size()) chk("bubble.order", 32'(emitted[i]), i + 1);

    // async reset mid-stream from FULL
    step("arst", 1'b1, 3'd1, 1'b0, 1'b0);
    step("arst", 1'b1, 3'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 0);
    chk("arst.in_ready",  32'(in_ready),  1);
    chk("arst.out_data",  32'(out_data),  0);
    q.delete();
    @(posedge clk);
    #1 chk("arst.hold_valid", 32'(out_valid), 0);
    #2 rst = 1'b1;
    step("arst.after", 1'b1, 3'd5, 1'b0, 1'b0);
    chk("arst.data5", 32'(out_data), 5);
    chk("arst.valid5", 32'(out_valid), 1);
    step("arst.drain", 1'b0, '0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom), W'($urandom), 1'($urandom), ($urandom % 16) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
